// File: rtl/plugboard_pkg.sv
// Shared definitions for the programmable Enigma plugboard:
// config opcodes, FSM state encoding and a letter range helper.
package plugboard_pkg;

    localparam logic [1:0] OP_PLUG   = 2'b00;
    localparam logic [1:0] OP_UNPLUG = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    function automatic logic in_range(input int x, input int n);
        return (x >= 1) && (x <= n);
    endfunction

endpackage

// File: rtl/plugboard_if.sv
// Letter stream and configuration bundle of the plugboard.
// The master side drives letters and commands, the slave side is the plugboard.
interface plugboard_if #(
    parameter int W  = 5,
    parameter int CW = 4
) ();

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_letter;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_letter;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_op;
    logic [W-1:0]  cfg_a;
    logic [W-1:0]  cfg_b;
    logic          cfg_done;
    logic          cfg_err;
    logic [CW-1:0] pair_count;

    modport master (
        output in_valid, in_letter, out_ready,
        output cfg_valid, cfg_op, cfg_a, cfg_b,
        input  in_ready, out_valid, out_letter,
        input  cfg_ready, cfg_done, cfg_err, pair_count
    );

    modport slave (
        input  in_valid, in_letter, out_ready,
        input  cfg_valid, cfg_op, cfg_a, cfg_b,
        output in_ready, out_valid, out_letter,
        output cfg_ready, cfg_done, cfg_err, pair_count
    );

endinterface

// File: rtl/plug_table.sv
// Letter swap table: three combinational lookups, two pair-write ports
// and a clear port that restores one identity entry per cycle.
module plug_table #(
    parameter int W         = 5,
    parameter int N_LETTERS = 26
) (
    input  logic         clk,
    input  logic [W-1:0] rd_d_addr,
    output logic [W-1:0] rd_d_data,
    input  logic [W-1:0] rd_a_addr,
    output logic [W-1:0] rd_a_data,
    input  logic [W-1:0] rd_b_addr,
    output logic [W-1:0] rd_b_data,
    input  logic         wr0_en,
    input  logic [W-1:0] wr0_addr,
    input  logic [W-1:0] wr0_data,
    input  logic         wr1_en,
    input  logic [W-1:0] wr1_addr,
    input  logic [W-1:0] wr1_data,
    input  logic         clr_en,
    input  logic [W-1:0] clr_idx
);

    logic [W-1:0] map_q [1:N_LETTERS];
    logic [W-1:0] map_d [1:N_LETTERS];

    // Codes outside 1..N_LETTERS read back as themselves
    always_comb begin
        rd_d_data = rd_d_addr;
        rd_a_data = rd_a_addr;
        rd_b_data = rd_b_addr;
        for (int i = 1; i <= N_LETTERS; i++) begin
            if (rd_d_addr == W'(i)) rd_d_data = map_q[i];
            if (rd_a_addr == W'(i)) rd_a_data = map_q[i];
            if (rd_b_addr == W'(i)) rd_b_data = map_q[i];
        end
    end

    always_comb begin
        map_d = map_q;
        for (int i = 1; i <= N_LETTERS; i++) begin
            if (wr0_en && wr0_addr == W'(i)) map_d[i] = wr0_data;
            if (wr1_en && wr1_addr == W'(i)) map_d[i] = wr1_data;
            if (clr_en && clr_idx == W'(i))  map_d[i] = W'(i);
        end
    end

    always_ff @(posedge clk) begin
        map_q <= map_d;
    end

endmodule

// File: rtl/plugboard_prog.sv
// Run-time programmable Enigma plugboard with a 1-cycle valid/ready
// letter stage and a single-command configuration port.
module plugboard_prog
    import plugboard_pkg::*;
#(
    parameter int W         = 5,
    parameter int N_LETTERS = 26,
    parameter int MAX_PAIRS = 10,
    parameter int CW        = $clog2(MAX_PAIRS + 1)
) (
    input logic      clk,
    input logic      rst,
    plugboard_if.slave bus
);

    state_e        state_q, state_d;
    logic [W-1:0]  idx_q, idx_d;
    logic          clr_cmd_q, clr_cmd_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_letter_q, out_letter_d;
    logic          cfg_done_q, cfg_done_d;
    logic          cfg_err_q, cfg_err_d;
    logic [CW-1:0] pair_count_q, pair_count_d;

    logic [W-1:0] map_in, map_a, map_b;
    logic         wr0_en, wr1_en, clr_en;
    logic [W-1:0] wr0_addr, wr0_data;
    logic [W-1:0] wr1_addr, wr1_data;
    logic         idle, in_acc;
    logic         a_ok, b_ok;

    plug_table #(
        .W         (W),
        .N_LETTERS (N_LETTERS)
    ) u_table (
        .clk       (clk),
        .rd_d_addr (bus.in_letter),
        .rd_d_data (map_in),
        .rd_a_addr (bus.cfg_a),
        .rd_a_data (map_a),
        .rd_b_addr (bus.cfg_b),
        .rd_b_data (map_b),
        .wr0_en    (wr0_en),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .clr_en    (clr_en),
        .clr_idx   (idx_q)
    );

    assign idle   = (state_q == ST_IDLE);
    assign in_acc = bus.in_valid && bus.in_ready;
    assign a_ok   = in_range(32'(bus.cfg_a), N_LETTERS);
    assign b_ok   = in_range(32'(bus.cfg_b), N_LETTERS);

    assign bus.in_ready   = idle && (!out_valid_q || bus.out_ready);
    assign bus.cfg_ready  = idle;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_letter = out_letter_q;
    assign bus.cfg_done   = cfg_done_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.pair_count = pair_count_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        clr_cmd_d    = clr_cmd_q;
        out_valid_d  = out_valid_q;
        out_letter_d = out_letter_q;
        cfg_done_d   = 1'b0;
        cfg_err_d    = 1'b0;
        pair_count_d = pair_count_q;
        wr0_en       = 1'b0;
        wr0_addr     = bus.cfg_a;
        wr0_data     = bus.cfg_b;
        wr1_en       = 1'b0;
        wr1_addr     = bus.cfg_b;
        wr1_data     = bus.cfg_a;
        clr_en       = 1'b0;

        // The letter reads the table before any same-cycle update lands
        if (in_acc) begin
            out_valid_d  = 1'b1;
            out_letter_d = map_in;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end

        case (state_q)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (idx_q == W'(N_LETTERS)) begin
                    state_d    = ST_IDLE;
                    idx_d      = W'(1);
                    cfg_done_d = clr_cmd_q;
                    clr_cmd_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                if (bus.cfg_valid) begin
                    case (bus.cfg_op)
                        OP_PLUG: begin
                            if (a_ok && b_ok && bus.cfg_a != bus.cfg_b &&
                                map_a == bus.cfg_a && map_b == bus.cfg_b &&
                                pair_count_q < CW'(MAX_PAIRS)) begin
                                wr0_en       = 1'b1;
                                wr1_en       = 1'b1;
                                pair_count_d = pair_count_q + 1'b1;
                                cfg_done_d   = 1'b1;
                            end else begin
                                cfg_err_d = 1'b1;
                            end
                        end
                        OP_UNPLUG: begin
                            if (a_ok && map_a != bus.cfg_a) begin
                                wr0_en       = 1'b1;
                                wr0_data     = bus.cfg_a;
                                wr1_en       = 1'b1;
                                wr1_addr     = map_a;
                                wr1_data     = map_a;
                                pair_count_d = pair_count_q - 1'b1;
                                cfg_done_d   = 1'b1;
                            end else begin
                                cfg_err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            state_d      = ST_CLEAR;
                            idx_d        = W'(1);
                            clr_cmd_d    = 1'b1;
                            pair_count_d = '0;
                        end
                        default: begin
                            cfg_err_d = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            idx_q        <= W'(1);
            clr_cmd_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_letter_q <= '0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            clr_cmd_q    <= clr_cmd_d;
            out_valid_q  <= out_valid_d;
            out_letter_q <= out_letter_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
            pair_count_q <= pair_count_d;
        end
    end

endmodule

// File: tb/tb_plugboard_prog.sv
// Self-checking bench for plugboard_prog: directed vector table,
// multi-cycle corner sequences and a randomized run against a pair model.
module tb_plugboard_prog;
    import plugboard_pkg::*;

    localparam int N    = 26;
    localparam int MAXP = 10;
    localparam int LIM  = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plugboard_if #(.W(5), .CW(4)) bus ();

    plugboard_prog #(
        .W(5), .N_LETTERS(N), .MAX_PAIRS(MAXP), .CW(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: partner of every letter (itself when unplugged)
    int pmap [32];
    int pcnt;

    typedef struct {
        int letter;
        int exp;
    } vec_t;
    vec_t vecs [32];

    function automatic int ref_map(input int x);
        return (x >= 1 && x <= N) ? pmap[x] : x;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) pmap[i] = i;
        pcnt = 0;
    endfunction

    function automatic bit model_apply(input int op, input int a, input int b);
        bit ra, rb;
        ra = (a >= 1 && a <= N);
        rb = (b >= 1 && b <= N);
        if (op == 0) begin
            if (!ra || !rb || a == b) return 1'b0;
            if (pmap[a] != a || pmap[b] != b || pcnt == MAXP) return 1'b0;
            pmap[a] = b;
            pmap[b] = a;
            pcnt++;
            return 1'b1;
        end
        if (op == 1) begin
            int p;
            if (!ra || pmap[a] == a) return 1'b0;
            p = pmap[a];
            pmap[a] = a;
            pmap[p] = p;
            pcnt--;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, LIM);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_letter(input int x, input int exp);
        int n;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'(x);
        while (!bus.in_ready && n < LIM) begin
            tick();
            n++;
        end
        if (n >= LIM) timeout("in_ready");
        tick();
        bus.in_valid = 1'b0;
        chk("out_valid", int'(bus.out_valid), 1);
        chk($sformatf("letter_%0d", x), int'(bus.out_letter), exp);
    endtask

    task automatic send_cfg(input int op, input int a, input int b);
        int n;
        bit ok;
        n = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = 2'(op);
        bus.cfg_a     = 5'(a);
        bus.cfg_b     = 5'(b);
        while (!bus.cfg_ready && n < LIM) begin
            tick();
            n++;
        end
        if (n >= LIM) timeout("cfg_ready");
        ok = model_apply(op, a, b);
        tick();
        bus.cfg_valid = 1'b0;
        chk($sformatf("done_op%0d_%0d_%0d", op, a, b), int'(bus.cfg_done), int'(ok));
        chk($sformatf("err_op%0d_%0d_%0d", op, a, b), int'(bus.cfg_err), int'(!ok));
        chk("pair_count", int'(bus.pair_count), pcnt);
    endtask

    task automatic sweep();
        for (int x = 0; x < 32; x++) send_letter(x, ref_map(x));
    endtask

    // Counts cycles with in_ready low; flags any cfg_done seen meanwhile
    task automatic count_clear(output int n, output bit done_seen);
        n = 0;
        done_seen = 1'b0;
        while (!bus.in_ready && n < LIM) begin
            if (bus.cfg_done) done_seen = 1'b1;
            tick();
            n++;
        end
        if (n >= LIM) timeout("clear_end");
    endtask

    initial begin
        int  n;
        bit  ds;
        int  exp;

        bus.in_valid  = 1'b0;
        bus.in_letter = '0;
        bus.out_ready = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_op    = '0;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        model_clear();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_letter", int'(bus.out_letter), 0);
        chk("rst_cfg_done", int'(bus.cfg_done), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        chk("rst_pair_count", int'(bus.pair_count), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 0);

        // Reset clear with a letter already waiting
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd2;
        rst = 1'b0;
        count_clear(n, ds);
        chk("rst_clear_cycles", n, 26);
        chk("rst_clear_no_done", int'(ds | bus.cfg_done), 0);
        tick();
        bus.in_valid = 1'b0;
        chk("first_out_valid", int'(bus.out_valid), 1);
        chk("first_out_letter", int'(bus.out_letter), 2);
        chk("first_pair_count", int'(bus.pair_count), 0);

        // Six pairs, then a directed table sweep
        send_cfg(0, 1, 2);
        send_cfg(0, 11, 13);
        send_cfg(0, 12, 25);
        send_cfg(0, 5, 21);
        send_cfg(0, 15, 16);
        send_cfg(0, 18, 19);
        chk("six_pairs", int'(bus.pair_count), 6);

        for (int i = 0; i < 32; i++) vecs[i] = '{i, i};
        vecs[1]  = '{1, 2};   vecs[2]  = '{2, 1};
        vecs[11] = '{11, 13}; vecs[13] = '{13, 11};
        vecs[12] = '{12, 25}; vecs[25] = '{25, 12};
        vecs[5]  = '{5, 21};  vecs[21] = '{21, 5};
        vecs[15] = '{15, 16}; vecs[16] = '{16, 15};
        vecs[18] = '{18, 19}; vecs[19] = '{19, 18};
        for (int i = 0; i < 32; i++) send_letter(vecs[i].letter, vecs[i].exp);

        // Rejected plugs leave everything unchanged
        send_cfg(0, 2, 7);
        send_cfg(0, 3, 3);
        send_cfg(0, 0, 4);
        send_cfg(0, 3, 4);
        send_cfg(0, 6, 7);
        send_cfg(0, 8, 9);
        send_cfg(0, 10, 14);
        chk("full_count", int'(bus.pair_count), 10);
        send_cfg(0, 17, 20);
        sweep();

        // Unplug and repeated unplug
        send_cfg(1, 2, 0);
        send_letter(1, 1);
        send_letter(2, 2);
        send_cfg(1, 2, 0);
        send_cfg(3, 4, 5);
        send_cfg(0, 1, 2);

        // Backpressure holds the output register
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_letter", int'(bus.out_letter), 2);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_drained", int'(bus.out_valid), 0);

        // Letter and plug accepted together: letter sees old table
        send_cfg(1, 1, 0);
        send_cfg(1, 8, 0);
        exp = ref_map(1);
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd1;
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = OP_PLUG;
        bus.cfg_a     = 5'd1;
        bus.cfg_b     = 5'd9;
        chk("same_ready", int'(bus.in_ready & bus.cfg_ready), 1);
        void'(model_apply(0, 1, 9));
        tick();
        bus.in_valid  = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("same_letter", int'(bus.out_letter), exp);
        chk("same_done", int'(bus.cfg_done), 1);
        send_letter(1, 9);

        // CLEAR with the stream running
        exp = ref_map(5);
        tick();
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd5;
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = OP_CLEAR;
        tick();
        bus.cfg_valid = 1'b0;
        model_clear();
        chk("clr_inflight_valid", int'(bus.out_valid), 1);
        chk("clr_inflight_letter", int'(bus.out_letter), exp);
        chk("clr_count_entry", int'(bus.pair_count), 0);
        count_clear(n, ds);
        chk("clr_cycles", n, 26);
        chk("clr_early_done", int'(ds), 0);
        chk("clr_done", int'(bus.cfg_done), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("clr_done_pulse", int'(bus.cfg_done), 0);
        chk("clr_identity", int'(bus.out_letter), 5);
        sweep();

        // Reset in the middle of a commanded clear
        send_cfg(0, 1, 2);
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = OP_CLEAR;
        tick();
        bus.cfg_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        count_clear(n, ds);
        chk("rclr_cycles", n, 26);
        chk("rclr_no_done", int'(ds | bus.cfg_done), 0);
        tick();
        chk("rclr_no_done_late", int'(bus.cfg_done), 0);
        chk("rclr_pair_count", int'(bus.pair_count), 0);
        send_letter(1, 1);

        // Randomized commands and letters against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                int x;
                x = $urandom_range(0, 31);
                send_letter(x, ref_map(x));
            end else if (r < 7) begin
                send_cfg(0, $urandom_range(0, 27), $urandom_range(0, 27));
            end else if (r < 9) begin
                send_cfg(1, $urandom_range(0, 27), $urandom_range(0, 31));
            end else begin
                send_cfg(3, $urandom_range(1, 26), $urandom_range(1, 26));
            end
        end
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
